// File: rtl/timer_irq_source_if.sv
// Bus-side signal bundle of the countdown timer: word-addressed register
// access plus the interrupt request line toward CP0 HWInt.
interface timer_irq_source_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_irq_source.sv
// Memory-mapped countdown timer raising one HWInt request line; one-shot
// (level IRQ held until acknowledged) or auto-reload (one pulse per period).
module timer_irq_source #(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    timer_irq_source_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    logic [1:0]  state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        enable;
    logic        auto_reload;
    logic        wr_ctrl;
    logic        wr_preset;

    assign enable      = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign wr_ctrl     = bus.WE && (bus.Addr == A_CTRL);
    assign wr_preset   = bus.WE && (bus.Addr == A_PRESET);

    // Statement order encodes priority: bus ack before the FSM so an expiry
    // set wins, bus CTRL write after the FSM so it beats the hardware clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            preset   <= PRESET_RST;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_ctrl || wr_preset)
                irq_flag <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    count    <= preset;
                    irq_flag <= 1'b0;
                    state    <= S_CNT;
                end
                S_CNT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    // Reload is folded into INT so the period is max(N,1)+1
                    // and the pulse lasts one cycle.
                    if (auto_reload) begin
                        count    <= preset;
                        irq_flag <= 1'b0;
                        state    <= S_CNT;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (wr_ctrl)
                ctrl <= bus.Din[3:0];
            if (wr_preset)
                preset <= bus.Din;
        end
    end

    always_comb begin
        bus.Dout = '0;
        case (bus.Addr)
            A_CTRL:   bus.Dout = {28'b0, ctrl};
            A_PRESET: bus.Dout = preset;
            A_COUNT:  bus.Dout = count;
            default:  bus.Dout = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & ctrl[3];

endmodule
